uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first, line idles high.
- Pairs with the team's existing UART transmitter on the same clk_50m domain.
- Samples the asynchronous rx line using a clock-enable tick at OVERSAMPLE times the baud rate, from the shared baud generator.
- Delivers each byte with a sticky ready flag cleared by the consumer, plus framing and overrun status.

Parameters:
OVERSAMPLE, 16, clken ticks per bit period; must be even and >= 4
SYNC_STAGES, 2, flops in the rx metastability synchroniser; must be >= 2

Ports:
clk_50m  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  asynchronous serial input line
clken  input  1  one-cycle sample tick at OVERSAMPLE x baud
rdy_clr  input  1  consumer acknowledge; clears rdy, frame_err and overrun
dout  output  8  last correctly framed byte
rdy  output  1  new byte available in dout (sticky)
frame_err  output  1  stop bit sampled low (sticky)
overrun  output  1  byte completed while rdy was still set (sticky)
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset, sampled while rst_n=0 on a clk_50m edge:
  - Synchroniser flops go to 1; state goes to IDLE; sample counter and bitpos go to 0.
  - dout=0x00, rdy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the partial byte with no flag set.
- rx_s is the synchroniser output. All decisions use rx_s and act only on cycles with clken=1, except IDLE entry detection and rdy_clr.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - If rx_s=0, go to START with cnt=0.
  - Detection happens on any clk_50m cycle; clken is not required.
- START (cnt increments on each clken):
  - On the clken where cnt = OVERSAMPLE/2-1 (mid start bit), check rx_s.
  - rx_s=0: go to DATA with cnt=0, bitpos=0.
  - rx_s=1: glitch; return to IDLE with no flags changed.
- DATA:
  - On the clken where cnt = OVERSAMPLE-1, shift: data[bitpos] <= rx_s, then cnt=0.
  - If bitpos=7, go to STOP; otherwise bitpos increments.
- STOP:
  - On the clken where cnt = OVERSAMPLE-1, sample the stop bit.
  - rx_s=1:
    - dout <= data, rdy <= 1, go to IDLE.
    - If rdy was already 1 and rdy_clr=0 that cycle, also set overrun=1; dout is overwritten with the new byte.
  - rx_s=0: set frame_err=1; dout and rdy unchanged; go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE.
  - Prevents a break or stuck-low line from being read as repeated start bits.
- Latency: rdy rises on the clk_50m edge of the clken tick sampling mid stop bit, i.e. one cycle after that tick is presented.
- rdy_clr=1 clears rdy, frame_err and overrun on the next edge.
- Simultaneous rdy_clr and byte completion: completion wins, so rdy=1, dout takes the new byte and overrun stays 0. Likewise frame_err=1 if that completion is a framing error.
- rx_busy is combinational: state != IDLE.
- clken is ignored in IDLE; counters never advance without clken.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampling one even-parity bit at mid-bit (cnt = OVERSAMPLE-1).
  - Adds output port parity_err (1 bit, reset 0, sticky, cleared by rdy_clr).
  - Mismatch (XOR of data and parity bit != 0): parity_err=1. If the stop bit is good, dout and rdy still update normally.
  - Frame length is 11 bit periods.
- Undefined: no PARITY state, no parity_err port; frame is 10 bit periods.

Test Plan:
Stimulus: clken is a one-cycle pulse every 27 clk_50m cycles, OVERSAMPLE=16, so one bit = 432 cycles.
1. Send 0x55 8N1, rdy_clr low → dout=0x55, rdy=1 at stop-bit mid-sample, frame_err=0, overrun=0, rx_busy falls the same edge.
2. rx low for 4 clken ticks then high (glitch) → no rdy, frame_err=0; rx_busy high about 4-8 ticks then 0; following byte 0xA5 received as 0xA5.
3. Send 0xA3 with stop bit 0, line held low 40 more bit periods, then high, then byte 0x3C → frame_err=1, rdy=0, dout stays 0x00 during the low period; then dout=0x3C, rdy=1.
4. Send 0x12 then 0x34 back-to-back without rdy_clr → dout=0x34, rdy=1, overrun=1; one-cycle rdy_clr → rdy=0, overrun=0 next edge.
5. Assert rst_n=0 for 2 cycles during data bit 3 of 0xFF → all outputs 0, state IDLE; next byte 0xF0 received as 0xF0 with no flags.
6. UART_RX_PARITY_EN: send 0x07 with parity bit 0 (expected 1), valid stop → dout=0x07, rdy=1, parity_err=1; send 0x07 with parity 1 after rdy_clr → parity_err=0.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling a synchronised rx line on an OVERSAMPLE x baud clock enable.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err status output.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bitpos, bitpos_d;
  logic [7:0]       shreg, shreg_d;
  logic [7:0]       dout_d;
  logic             rdy_d, frame_err_d, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_d;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_busy   = (state != IDLE);
  assign state_dbg = state;

  // Consumer handshake: rdy is a sticky valid that rises when a byte lands in dout and
  // falls one edge after rdy_clr; a completion on the same edge as rdy_clr takes priority.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bitpos_d    = bitpos;
    shreg_d     = shreg;
    dout_d      = dout;
    rdy_d       = rdy & ~rdy_clr;
    frame_err_d = frame_err & ~rdy_clr;
    overrun_d   = overrun & ~rdy_clr;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err & ~rdy_clr;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (clken) begin
          if (cnt == CNT_HALF) begin
            cnt_d    = '0;
            bitpos_d = '0;
            state_d  = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      DATA: begin
        if (clken) begin
          if (cnt == CNT_LAST) begin
            cnt_d           = '0;
            shreg_d[bitpos] = rx_s;
            if (bitpos == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bitpos_d = bitpos + 3'd1;
            end
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clken) begin
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = STOP;
            if (^{shreg, rx_s}) parity_err_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
`endif
      STOP: begin
        if (clken) begin
          if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              dout_d  = shreg;
              rdy_d   = 1'b1;
              state_d = IDLE;
              if (rdy && !rdy_clr) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      // A break or stuck-low line must return high before a new start bit is accepted.
      WAIT_HIGH: begin
        if (clken && rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitpos    <= '0;
      shreg     <= '0;
      dout      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bitpos    <= bitpos_d;
      shreg     <= shreg_d;
      dout      <= dout_d;
      rdy       <= rdy_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_err_d;
`endif
    end
  end

endmodule
